mshr_replay_sched: RTL and testbench

Replay scheduler between the MSHR FIFO's negative-feedback return port and the memory pipeline's issue port. When the MSHR retires a miss, it reports scbID, warpID and address. This block parks each return in a per-warp replay slot and marks the warp stalled. It then offers one replay at a time to the memory pipeline over a valid/ready handshake, choosing among warps round-robin. Issue is throttled while the MSHR is near full, so replays cannot re-miss into a saturated FIFO.

---
 rtl/mem_pkg.sv | 16 +
 rtl/rr_pick.sv | 34 +++
 rtl/mshr_replay_sched.sv | 116 +++++++++++
 tb/tb_mshr_replay_sched.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared memory-subsystem definitions used by the MSHR FIFO, the memory
// pipeline and the replay scheduler.
//   WARP_W / SCB_W / ADDR_W : field widths of an MSHR retire record
//   replay_state_e          : replay scheduler FSM state encoding
package mem_pkg;

  localparam int unsigned WARP_W = 3;
  localparam int unsigned SCB_W  = 2;
  localparam int unsigned ADDR_W = 27;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } replay_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin first-set-bit finder.
//   i_req   : request mask, one bit per warp
//   i_start : scan start index; scan wraps NUM_WARPS-1 -> 0
//   o_grant : first requesting index at or after i_start
//   o_any   : at least one request bit set
module rr_pick
  import mem_pkg::*;
#(
  parameter int unsigned NUM_WARPS = 8,
  parameter int unsigned WARP_W    = mem_pkg::WARP_W
) (
  input  logic [NUM_WARPS-1:0] i_req,
  input  logic [WARP_W-1:0]    i_start,
  output logic [WARP_W-1:0]    o_grant,
  output logic                 o_any
);

  int unsigned w_idx;

  // Cyclic scan from i_start; the first hit is kept.
  always_comb begin
    o_grant = '0;
    o_any   = 1'b0;
    w_idx   = 0;
    for (int unsigned k = 0; k < NUM_WARPS; k++) begin
      w_idx = (32'(i_start) + k) % NUM_WARPS;
      if (!o_any && i_req[WARP_W'(w_idx)]) begin
        o_grant = WARP_W'(w_idx);
        o_any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mshr_replay_sched.sv
// Replay scheduler between the MSHR negative-feedback port and the memory
// pipeline issue port. Each MSHR retire parks in a per-warp replay slot
// (warp marked stalled); slots are offered one at a time, round-robin,
// over a valid/ready handshake. New grants are blocked while the MSHR is
// near full.
//   clk, resetb        : clock, synchronous active-low reset
//   fb_*               : MSHR retire record (valid, scbID, warpID, addr)
//   mshr_throttle      : MSHR almost-full, blocks new grants in IDLE
//   replay_valid/ready : handshake to the memory pipeline
//   replay_*           : offered payload, stable while replay_valid
//   pending_mask       : per-warp slot occupied (warp stall)
//   overflow           : sticky, a retire hit an occupied slot and was lost
module mshr_replay_sched
  import mem_pkg::*;
#(
  parameter int unsigned NUM_WARPS = 8,
  parameter int unsigned WARP_W    = mem_pkg::WARP_W,
  parameter int unsigned SCB_W     = mem_pkg::SCB_W,
  parameter int unsigned ADDR_W    = mem_pkg::ADDR_W
) (
  input  logic                 clk,
  input  logic                 resetb,
  input  logic                 fb_valid,
  input  logic [SCB_W-1:0]     fb_scbID,
  input  logic [WARP_W-1:0]    fb_warpID,
  input  logic [ADDR_W-1:0]    fb_addr,
  input  logic                 mshr_throttle,
  output logic                 replay_valid,
  input  logic                 replay_ready,
  output logic [SCB_W-1:0]     replay_scbID,
  output logic [WARP_W-1:0]    replay_warpID,
  output logic [ADDR_W-1:0]    replay_addr,
  output logic [NUM_WARPS-1:0] pending_mask,
  output logic                 overflow
);

  replay_state_e        r_state;
  logic [WARP_W-1:0]    r_rr_ptr;
  logic [NUM_WARPS-1:0] r_pending;
  logic [SCB_W-1:0]     r_scb  [NUM_WARPS];
  logic [ADDR_W-1:0]    r_addr [NUM_WARPS];

  logic [WARP_W-1:0]    w_pick;
  logic                 w_any;
  logic                 w_accept;
  logic                 w_fb_drop;
  logic                 w_fb_load;

  rr_pick #(
    .NUM_WARPS (NUM_WARPS),
    .WARP_W    (WARP_W)
  ) u_rr_pick (
    .i_req   (r_pending),
    .i_start (r_rr_ptr),
    .o_grant (w_pick),
    .o_any   (w_any)
  );

  // replay_warpID doubles as the latched grant while in OFFER.
  assign w_accept  = (r_state == OFFER) && replay_ready;
  // An occupied slot only accepts a new retire in the cycle it is being drained.
  assign w_fb_drop = fb_valid && r_pending[fb_warpID] &&
                     !(w_accept && (fb_warpID == replay_warpID));
  assign w_fb_load = fb_valid && !w_fb_drop;

  assign pending_mask = r_pending;

  // Slot payload storage; contents are don't-care while the pending bit is 0.
  always_ff @(posedge clk) begin
    if (w_fb_load) begin
      r_scb[fb_warpID]  <= fb_scbID;
      r_addr[fb_warpID] <= fb_addr;
    end
  end

  // Grant/offer FSM, pending bits and sticky overflow.
  always_ff @(posedge clk) begin
    if (!resetb) begin
      r_state      <= IDLE;
      r_rr_ptr     <= '0;
      r_pending    <= '0;
      replay_valid <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any && !mshr_throttle) begin
            replay_valid  <= 1'b1;
            replay_warpID <= w_pick;
            replay_scbID  <= r_scb[w_pick];
            replay_addr   <= r_addr[w_pick];
            r_state       <= OFFER;
          end
        end
        OFFER: begin
          if (replay_ready) begin
            r_pending[replay_warpID] <= 1'b0;
            r_rr_ptr <= (replay_warpID == WARP_W'(NUM_WARPS - 1)) ?
                        '0 : replay_warpID + WARP_W'(1);
            replay_valid <= 1'b0;
            r_state      <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
      // Placed after the clear so a same-slot load in the accept cycle wins.
      if (w_fb_load) begin
        r_pending[fb_warpID] <= 1'b1;
      end
      if (w_fb_drop) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mshr_replay_sched.sv
module tb_mshr_replay_sched;

  logic        clk = 1'b0;
  logic        resetb;
  logic        fb_valid;
  logic [1:0]  fb_scbID;
  logic [2:0]  fb_warpID;
  logic [26:0] fb_addr;
  logic        mshr_throttle;
  logic        replay_valid;
  logic        replay_ready;
  logic [1:0]  replay_scbID;
  logic [2:0]  replay_warpID;
  logic [26:0] replay_addr;
  logic [7:0]  pending_mask;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mshr_replay_sched dut (
    .clk           (clk),
    .resetb        (resetb),
    .fb_valid      (fb_valid),
    .fb_scbID      (fb_scbID),
    .fb_warpID     (fb_warpID),
    .fb_addr       (fb_addr),
    .mshr_throttle (mshr_throttle),
    .replay_valid  (replay_valid),
    .replay_ready  (replay_ready),
    .replay_scbID  (replay_scbID),
    .replay_warpID (replay_warpID),
    .replay_addr   (replay_addr),
    .pending_mask  (pending_mask),
    .overflow      (overflow)
  );

  // Advance one edge and settle; inputs set afterwards apply at the next edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fb(input logic [2:0] w, input logic [1:0] s, input logic [26:0] a);
    fb_valid  = 1'b1;
    fb_warpID = w;
    fb_scbID  = s;
    fb_addr   = a;
  endtask

  task automatic test_reset();
    resetb = 1'b0; fb_valid = 1'b0; fb_scbID = '0; fb_warpID = '0; fb_addr = '0;
    mshr_throttle = 1'b0; replay_ready = 1'b0;
    step(); step();
    resetb = 1'b1;
    checks++; if (replay_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", replay_valid); end
    checks++; if (pending_mask !== 8'h00) begin errors++; $display("FAIL reset_pending got %h want 00", pending_mask); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b want 0", overflow); end
  endtask

  task automatic test_single();
    fb(3'd3, 2'd1, 27'h0ABCDEF);
    step();
    fb_valid = 1'b0;
    checks++; if (pending_mask !== 8'h08) begin errors++; $display("FAIL single_pend got %h want 08", pending_mask); end
    checks++; if (replay_valid !== 1'b0) begin errors++; $display("FAIL single_early got %b want 0", replay_valid); end
    step();
    checks++; if (replay_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b want 1", replay_valid); end
    checks++; if (replay_warpID !== 3'd3) begin errors++; $display("FAIL single_warp got %0d want 3", replay_warpID); end
    checks++; if (replay_scbID !== 2'd1) begin errors++; $display("FAIL single_scb got %0d want 1", replay_scbID); end
    checks++; if (replay_addr !== 27'h0ABCDEF) begin errors++; $display("FAIL single_addr got %h want 0abcdef", replay_addr); end
    replay_ready = 1'b1;
    step();
    replay_ready = 1'b0;
    checks++; if (pending_mask !== 8'h00) begin errors++; $display("FAIL single_clear got %h want 00", pending_mask); end
    checks++; if (replay_valid !== 1'b0) begin errors++; $display("FAIL single_drop got %b want 0", replay_valid); end
  endtask

  // rr_ptr is 4 here, so the cyclic order over {0,2,7} is 7,0,2.
  task automatic test_rr_wrap();
    logic       exp_v [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [2:0] exp_w [5] = '{3'd7, 3'd0, 3'd0, 3'd2, 3'd2};
    mshr_throttle = 1'b1;
    fb(3'd0, 2'd0, 27'h0000100); step();
    fb(3'd2, 2'd2, 27'h0000200); step();
    fb(3'd7, 2'd3, 27'h0000700); step();
    fb_valid = 1'b0;
    checks++; if (pending_mask !== 8'h85) begin errors++; $display("FAIL rr_fill got %h want 85", pending_mask); end
    checks++; if (replay_valid !== 1'b0) begin errors++; $display("FAIL rr_throttled got %b want 0", replay_valid); end
    mshr_throttle = 1'b0;
    replay_ready  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (replay_valid !== exp_v[i]) begin errors++; $display("FAIL rr_valid[%0d] got %b want %b", i, replay_valid, exp_v[i]); end
      if (exp_v[i]) begin
        checks++;
        if (replay_warpID !== exp_w[i]) begin errors++; $display("FAIL rr_grant[%0d] got %0d want %0d", i, replay_warpID, exp_w[i]); end
      end
    end
    step();
    replay_ready = 1'b0;
    checks++; if (pending_mask !== 8'h00) begin errors++; $display("FAIL rr_empty got %h want 00", pending_mask); end
  endtask

  // rr_ptr is 3 on entry; warp 5 is offered and held while 1 and 6 arrive.
  task automatic test_backpressure();
    fb(3'd5, 2'd2, 27'h5555555); step();
    fb_valid = 1'b0;
    step();
    for (int i = 0; i < 10; i++) begin
      if (i == 0) fb(3'd1, 2'd1, 27'h0111111);
      else if (i == 1) fb(3'd6, 2'd0, 27'h0666666);
      else fb_valid = 1'b0;
      checks++;
      if (replay_valid !== 1'b1 || replay_warpID !== 3'd5 || replay_addr !== 27'h5555555 || replay_scbID !== 2'd2)
        begin errors++; $display("FAIL bp_hold[%0d] got v=%b w=%0d a=%h want v=1 w=5 a=5555555", i, replay_valid, replay_warpID, replay_addr); end
      step();
    end
    fb_valid = 1'b0;
    checks++; if (pending_mask !== 8'h62) begin errors++; $display("FAIL bp_pend got %h want 62", pending_mask); end
    replay_ready = 1'b1;
    step();
    step();
    checks++; if (replay_valid !== 1'b1 || replay_warpID !== 3'd6) begin errors++; $display("FAIL bp_next got v=%b w=%0d want v=1 w=6", replay_valid, replay_warpID); end
    checks++; if (replay_addr !== 27'h0666666) begin errors++; $display("FAIL bp_next_addr got %h want 0666666", replay_addr); end
    step();
    step();
    checks++; if (replay_valid !== 1'b1 || replay_warpID !== 3'd1) begin errors++; $display("FAIL bp_third got v=%b w=%0d want v=1 w=1", replay_valid, replay_warpID); end
    step();
    replay_ready = 1'b0;
    checks++; if (pending_mask !== 8'h00) begin errors++; $display("FAIL bp_empty got %h want 00", pending_mask); end
  endtask

  task automatic test_throttle();
    mshr_throttle = 1'b1;
    fb(3'd2, 2'd3, 27'h0222222); step();
    fb_valid = 1'b0;
    checks++; if (pending_mask !== 8'h04) begin errors++; $display("FAIL thr_pend got %h want 04", pending_mask); end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (replay_valid !== 1'b0) begin errors++; $display("FAIL thr_block[%0d] got %b want 0", i, replay_valid); end
    end
    mshr_throttle = 1'b0;
    step();
    checks++; if (replay_valid !== 1'b1 || replay_warpID !== 3'd2) begin errors++; $display("FAIL thr_release got v=%b w=%0d want v=1 w=2", replay_valid, replay_warpID); end
    mshr_throttle = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (replay_valid !== 1'b1) begin errors++; $display("FAIL thr_offer_held[%0d] got %b want 1", i, replay_valid); end
    end
    replay_ready = 1'b1;
    step();
    replay_ready = 1'b0;
    mshr_throttle = 1'b0;
    checks++; if (replay_valid !== 1'b0 || pending_mask !== 8'h00) begin errors++; $display("FAIL thr_accept got v=%b p=%h want v=0 p=00", replay_valid, pending_mask); end
  endtask

  // Accept-cycle load first (overflow still 0), then the dropping collision.
  task automatic test_collision();
    fb(3'd4, 2'd1, 27'h0AAAAAA); step();
    fb_valid = 1'b0;
    step();
    checks++; if (replay_valid !== 1'b1 || replay_addr !== 27'h0AAAAAA) begin errors++; $display("FAIL col_offer got v=%b a=%h want v=1 a=0aaaaaa", replay_valid, replay_addr); end
    replay_ready = 1'b1;
    fb(3'd4, 2'd2, 27'h0CCCCCC);
    step();
    fb_valid = 1'b0;
    replay_ready = 1'b0;
    checks++; if (pending_mask !== 8'h10) begin errors++; $display("FAIL col_accept_pend got %h want 10", pending_mask); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL col_accept_ovf got %b want 0", overflow); end
    step();
    checks++; if (replay_valid !== 1'b1 || replay_addr !== 27'h0CCCCCC || replay_scbID !== 2'd2) begin errors++; $display("FAIL col_new_payload got v=%b a=%h s=%0d want v=1 a=0cccccc s=2", replay_valid, replay_addr, replay_scbID); end
    fb(3'd4, 2'd3, 27'h0BBBBBB);
    step();
    fb_valid = 1'b0;
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL col_drop_ovf got %b want 1", overflow); end
    checks++; if (replay_addr !== 27'h0CCCCCC) begin errors++; $display("FAIL col_drop_addr got %h want 0cccccc", replay_addr); end
    replay_ready = 1'b1;
    step();
    replay_ready = 1'b0;
    checks++; if (pending_mask !== 8'h00) begin errors++; $display("FAIL col_drop_pend got %h want 00", pending_mask); end
    step();
    checks++; if (replay_valid !== 1'b0 || overflow !== 1'b1) begin errors++; $display("FAIL col_sticky got v=%b o=%b want v=0 o=1", replay_valid, overflow); end
  endtask

  task automatic test_reset_mid_offer();
    fb(3'd1, 2'd0, 27'h0123456); step();
    fb(3'd6, 2'd1, 27'h0654321); step();
    fb_valid = 1'b0;
    checks++; if (replay_valid !== 1'b1) begin errors++; $display("FAIL rst_mid_offer got %b want 1", replay_valid); end
    resetb = 1'b0;
    step();
    resetb = 1'b1;
    checks++; if (replay_valid !== 1'b0 || pending_mask !== 8'h00 || overflow !== 1'b0) begin errors++; $display("FAIL rst_mid got v=%b p=%h o=%b want v=0 p=00 o=0", replay_valid, pending_mask, overflow); end
    step();
    step();
    checks++; if (replay_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_quiet got %b want 0", replay_valid); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_rr_wrap();
    test_backpressure();
    test_throttle();
    test_collision();
    test_reset_mid_offer();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
